uart_chan_mux: RTL and testbench

- Shares one byte-wide UART serial channel pair (serial_out toward the host, serial_in from the host) between NCLIENTS on-chip requesters.
- TX path: round-robin arbitration between clients, with the grant locked for a whole frame. Each frame is length-prefixed and tagged with the client ID.
- RX path: parses incoming frames of the same format and routes each payload to the client named in its ID byte.
- Sits between the per-hart/per-device console streams and the single SimUART / UART PHY channel.

---
 rtl/uart_chan_mux_pkg.sv | 18 +
 rtl/uart_chan_mux_rr_arbiter.sv | 34 +++
 rtl/uart_chan_mux.sv | 182 ++++++++++++++++++
 tb/tb_uart_chan_mux.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_chan_mux_pkg.sv
// Shared types and frame-field constants for the UART channel multiplexer.
// Frame on the wire: {ID_BYTE_PAD, id}, LEN (payload bytes minus 1), payload.
package uart_chan_mux_pkg;

  localparam int MAX_CLIENTS = 16;
  localparam int ID_FIELD_W  = 4;
  localparam int LEN_W       = 8;
  localparam int BYTE_W      = 8;
  localparam logic [BYTE_W-ID_FIELD_W-1:0] ID_BYTE_PAD = 4'h0;

  typedef enum logic [1:0] {T_IDLE, T_ID, T_LEN, T_DATA} tx_state_e;
  typedef enum logic [1:0] {R_ID, R_LEN, R_DATA} rx_state_e;

  function automatic logic [BYTE_W-1:0] id_byte(input logic [ID_FIELD_W-1:0] id);
    return {ID_BYTE_PAD, id};
  endfunction

endpackage

// File: rtl/uart_chan_mux_rr_arbiter.sv
// Round-robin pick: first requester at or after ptr_i, searching cyclically.
// Purely combinational, zero latency; the pointer register lives in the parent.
module rr_arbiter #(
  parameter int NCLIENTS = 4,
  parameter int IDW      = $clog2(NCLIENTS)
) (
  input  logic [NCLIENTS-1:0] req_i,
  input  logic [IDW-1:0]      ptr_i,
  output logic [NCLIENTS-1:0] gnt_oh_o,
  output logic [IDW-1:0]      gnt_idx_o,
  output logic                any_o
);

  int             idx;
  logic [IDW-1:0] cand;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int off = 0; off < NCLIENTS; off++) begin
      idx  = (int'(ptr_i) + off) % NCLIENTS;
      cand = IDW'(idx);
      if (!any_o && req_i[cand]) begin
        any_o           = 1'b1;
        gnt_oh_o[cand]  = 1'b1;
        gnt_idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/uart_chan_mux.sv
// Muxes NCLIENTS byte streams onto one UART channel pair using ID/LEN-prefixed frames.
// TX grant costs one idle cycle per frame; payload bytes pass through combinationally both ways.
module uart_chan_mux
  import uart_chan_mux_pkg::*;
#(
  parameter int NCLIENTS   = 4,
  parameter int DATA_WIDTH = 8,
  parameter int IDW        = $clog2(NCLIENTS)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NCLIENTS-1:0]            cl_tx_valid,
  output logic [NCLIENTS-1:0]            cl_tx_ready,
  input  logic [NCLIENTS*DATA_WIDTH-1:0] cl_tx_bits,
  input  logic [NCLIENTS*DATA_WIDTH-1:0] cl_tx_len,
  output logic [NCLIENTS-1:0]            cl_rx_valid,
  input  logic [NCLIENTS-1:0]            cl_rx_ready,
  output logic [DATA_WIDTH-1:0]          cl_rx_bits,
  output logic                           serial_out_valid,
  input  logic                           serial_out_ready,
  output logic [DATA_WIDTH-1:0]          serial_out_bits,
  input  logic                           serial_in_valid,
  output logic                           serial_in_ready,
  input  logic [DATA_WIDTH-1:0]          serial_in_bits
);

  logic [DATA_WIDTH-1:0] tx_byte [NCLIENTS];
  logic [DATA_WIDTH-1:0] tx_len  [NCLIENTS];

  for (genvar i = 0; i < NCLIENTS; i++) begin : g_unpack
    assign tx_byte[i] = cl_tx_bits[i*DATA_WIDTH +: DATA_WIDTH];
    assign tx_len[i]  = cl_tx_len[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // ---------------- TX ----------------
  tx_state_e             tx_state_q, tx_state_d;
  logic [IDW-1:0]        gnt_q, gnt_d;
  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic [NCLIENTS-1:0]   arb_oh;
  logic [IDW-1:0]        arb_idx;
  logic                  arb_any;
  logic [DATA_WIDTH-1:0] len_sel;

  rr_arbiter #(.NCLIENTS(NCLIENTS), .IDW(IDW)) u_arb (
    .req_i    (cl_tx_valid),
    .ptr_i    (rr_ptr_q),
    .gnt_oh_o (arb_oh),
    .gnt_idx_o(arb_idx),
    .any_o    (arb_any)
  );

  always_comb begin
    len_sel = '0;
    for (int i = 0; i < NCLIENTS; i++) begin
      len_sel = len_sel | (tx_len[i] & {DATA_WIDTH{arb_oh[i]}});
    end
  end

  always_comb begin
    tx_state_d       = tx_state_q;
    gnt_d            = gnt_q;
    rr_ptr_d         = rr_ptr_q;
    cnt_d            = cnt_q;
    serial_out_valid = 1'b0;
    serial_out_bits  = '0;
    cl_tx_ready      = '0;
    case (tx_state_q)
      T_IDLE: begin
        if (arb_any) begin
          gnt_d      = arb_idx;
          cnt_d      = len_sel;
          tx_state_d = T_ID;
        end
      end
      T_ID: begin
        serial_out_valid = 1'b1;
        serial_out_bits  = id_byte(ID_FIELD_W'(gnt_q));
        if (serial_out_ready) tx_state_d = T_LEN;
      end
      T_LEN: begin
        serial_out_valid = 1'b1;
        serial_out_bits  = cnt_q;
        if (serial_out_ready) tx_state_d = T_DATA;
      end
      T_DATA: begin
        // Grant is held until the last payload byte, even if the client stalls.
        serial_out_valid   = cl_tx_valid[gnt_q];
        serial_out_bits    = tx_byte[gnt_q];
        cl_tx_ready[gnt_q] = serial_out_ready;
        if (cl_tx_valid[gnt_q] && serial_out_ready) begin
          if (cnt_q == '0) begin
            rr_ptr_d   = (gnt_q == IDW'(NCLIENTS-1)) ? '0 : gnt_q + 1'b1;
            tx_state_d = T_IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state_q <= T_IDLE;
      gnt_q      <= '0;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      gnt_q      <= gnt_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // ---------------- RX ----------------
  rx_state_e        rx_state_q, rx_state_d;
  logic [IDW-1:0]   sel_q, sel_d;
  logic             drop_q, drop_d;
  logic [LEN_W-1:0] cnt_rx_q, cnt_rx_d;
  logic             rx_hs;

  assign cl_rx_bits = serial_in_bits;
  assign rx_hs      = serial_in_valid && serial_in_ready;

  always_comb begin
    rx_state_d      = rx_state_q;
    sel_d           = sel_q;
    drop_d          = drop_q;
    cnt_rx_d        = cnt_rx_q;
    serial_in_ready = 1'b0;
    cl_rx_valid     = '0;
    case (rx_state_q)
      R_ID: begin
        serial_in_ready = reset;
        if (rx_hs) begin
          sel_d      = serial_in_bits[IDW-1:0];
          drop_d     = (serial_in_bits >= DATA_WIDTH'(NCLIENTS));
          rx_state_d = R_LEN;
        end
      end
      R_LEN: begin
        serial_in_ready = 1'b1;
        if (rx_hs) begin
          cnt_rx_d   = serial_in_bits;
          rx_state_d = R_DATA;
        end
      end
      R_DATA: begin
        // Frames for a nonexistent client are swallowed at full rate.
        if (drop_q) begin
          serial_in_ready = 1'b1;
        end else begin
          cl_rx_valid[sel_q] = serial_in_valid;
          serial_in_ready    = cl_rx_ready[sel_q];
        end
        if (rx_hs) begin
          if (cnt_rx_q == '0) rx_state_d = R_ID;
          else                cnt_rx_d   = cnt_rx_q - 1'b1;
        end
      end
      default: rx_state_d = R_ID;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_state_q <= R_ID;
      sel_q      <= '0;
      drop_q     <= 1'b0;
      cnt_rx_q   <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      sel_q      <= sel_d;
      drop_q     <= drop_d;
      cnt_rx_q   <= cnt_rx_d;
    end
  end

endmodule

// File: tb/tb_uart_chan_mux.sv
// Scoreboard bench for uart_chan_mux: stimulus pushes expected bytes, negedge monitors pop and compare.
module tb_uart_chan_mux;

  localparam int N = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [N-1:0]   cl_tx_valid, cl_tx_ready, cl_rx_valid, cl_rx_ready;
  logic [N*8-1:0] cl_tx_bits, cl_tx_len;
  logic [7:0]     cl_rx_bits, serial_out_bits, serial_in_bits;
  logic           serial_out_valid, serial_out_ready, serial_in_valid, serial_in_ready;

  logic       tx_v [N];
  logic [7:0] tx_b [N];
  logic [7:0] tx_l [N];

  for (genvar i = 0; i < N; i++) begin : g_drv
    assign cl_tx_valid[i]       = tx_v[i];
    assign cl_tx_bits[i*8 +: 8] = tx_b[i];
    assign cl_tx_len[i*8 +: 8]  = tx_l[i];
  end

  uart_chan_mux #(.NCLIENTS(N), .DATA_WIDTH(8)) dut (
    .clock           (clock),
    .reset           (reset),
    .cl_tx_valid     (cl_tx_valid),
    .cl_tx_ready     (cl_tx_ready),
    .cl_tx_bits      (cl_tx_bits),
    .cl_tx_len       (cl_tx_len),
    .cl_rx_valid     (cl_rx_valid),
    .cl_rx_ready     (cl_rx_ready),
    .cl_rx_bits      (cl_rx_bits),
    .serial_out_valid(serial_out_valid),
    .serial_out_ready(serial_out_ready),
    .serial_out_bits (serial_out_bits),
    .serial_in_valid (serial_in_valid),
    .serial_in_ready (serial_in_ready),
    .serial_in_bits  (serial_in_bits)
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  tx_q[$];
  logic [11:0] rx_q[$];
  int          rdy_cnt[N];
  logic [N-1:0] chk_mask = '0;
  bit          rand_rdy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors
  always @(negedge clock) begin
    if (reset) begin
      if (serial_out_valid && serial_out_ready) begin
        if (tx_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected: got byte %0h with nothing expected", serial_out_bits);
        end else begin
          check("tx_byte", 32'(serial_out_bits), 32'(tx_q.pop_front()));
        end
      end
      for (int i = 0; i < N; i++) if (cl_tx_ready[i]) rdy_cnt[i]++;
      if (cl_tx_ready != '0 && chk_mask != '0) check("tx_ready_mask", 32'(cl_tx_ready), 32'(chk_mask));
      if ((cl_rx_valid & cl_rx_ready) != '0) begin
        logic [11:0] got;
        got = '0;
        for (int i = 0; i < N; i++) if (cl_rx_valid[i]) got = {4'(i), cl_rx_bits};
        check("rx_valid_onehot", 32'($onehot(cl_rx_valid)), 32'd1);
        if (rx_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rx_unexpected: got client/byte %0h with nothing expected", got);
        end else begin
          check("rx_client_byte", 32'(got), 32'(rx_q.pop_front()));
        end
      end
    end
  end

  initial forever begin
    @(posedge clock); #1;
    serial_out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic exp_frame(input int c, input logic [7:0] len, input logic [7:0] d[$]);
    tx_q.push_back(8'(c));
    tx_q.push_back(len);
    foreach (d[k]) tx_q.push_back(d[k]);
  endtask

  task automatic send_tx(input int c, input logic [7:0] len, input logic [7:0] d[$]);
    int k = 0;
    int t = 0;
    bit hs;
    tx_l[c] = len;
    while (k < d.size()) begin
      tx_v[c] = 1'b1;
      tx_b[c] = d[k];
      @(negedge clock); hs = cl_tx_ready[c];
      @(posedge clock); #1;
      if (!reset) break;
      if (hs) k++;
      t++;
      if (t > 300) begin
        checks++; errors++;
        $display("FAIL tx_timeout: client %0d sent %0d of %0d bytes", c, k, d.size());
        break;
      end
    end
    tx_v[c] = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] b);
    int t = 0;
    bit hs = 1'b0;
    serial_in_valid = 1'b1;
    serial_in_bits  = b;
    while (!hs && t < 100) begin
      @(negedge clock); hs = serial_in_ready;
      @(posedge clock); #1;
      t++;
    end
    if (!hs) begin
      checks++; errors++;
      $display("FAIL rx_timeout: byte %0h got ready %0d required 1", b, serial_in_ready);
    end
    serial_in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while ((tx_q.size() != 0 || rx_q.size() != 0) && t < 200) begin
      @(negedge clock); #1; t++;
    end
    check({name, "_txq_empty"}, 32'(tx_q.size()), 32'd0);
    check({name, "_rxq_empty"}, 32'(rx_q.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clock); #1; reset = 1'b0;
    repeat (2) @(posedge clock);
    #1; reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin tx_v[i] = 1'b0; tx_b[i] = '0; tx_l[i] = '0; rdy_cnt[i] = 0; end
    cl_rx_ready = '1; serial_in_valid = 1'b0; serial_in_bits = '0; serial_out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_sout_valid", 32'(serial_out_valid), 32'd0);
    check("rst_tx_ready",   32'(cl_tx_ready),      32'd0);
    check("rst_rx_valid",   32'(cl_rx_valid),      32'd0);
    check("rst_sin_ready",  32'(serial_in_ready),  32'd0);
    @(posedge clock); #1; reset = 1'b1; #1;
    check("post_rst_sin_ready", 32'(serial_in_ready), 32'd1);

    // 1: single client 2, len 2
    chk_mask = 4'b0100;
    exp_frame(2, 8'd2, '{8'hA1, 8'hA2, 8'hA3});
    send_tx(2, 8'd2, '{8'hA1, 8'hA2, 8'hA3});
    wait_drain("t1");
    @(negedge clock);
    check("t1_idle_valid", 32'(serial_out_valid), 32'd0);
    check("t1_ready_cycles", 32'(rdy_cnt[2]), 32'd3);
    chk_mask = '0;

    // 2: clients 0 and 3 together from rr_ptr=0, twice
    pulse_reset();
    for (int r = 0; r < 2; r++) begin
      exp_frame(0, 8'd0, '{8'hB0 + 8'(r)});
      exp_frame(3, 8'd0, '{8'hC3 + 8'(r)});
      fork
        send_tx(0, 8'd0, '{8'hB0 + 8'(r)});
        send_tx(3, 8'd0, '{8'hC3 + 8'(r)});
      join
      wait_drain("t2");
    end

    // 3: client 1, len 4, random serial_out_ready
    chk_mask = 4'b0010; rand_rdy = 1'b1;
    exp_frame(1, 8'd4, '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55});
    send_tx(1, 8'd4, '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55});
    wait_drain("t3");
    chk_mask = '0; rand_rdy = 1'b0;
    @(posedge clock); #1;

    // 4: RX frame to client 1 with a 3-cycle stall on the last byte
    rx_q.push_back({4'd1, 8'h55});
    rx_q.push_back({4'd1, 8'h66});
    rx_send(8'h01); rx_send(8'h01); rx_send(8'h55);
    cl_rx_ready[1] = 1'b0; serial_in_valid = 1'b1; serial_in_bits = 8'h66;
    repeat (3) begin
      @(negedge clock);
      check("t4_stall_sin_ready", 32'(serial_in_ready), 32'd0);
      check("t4_stall_rx_valid",  32'(cl_rx_valid),     32'b0010);
      @(posedge clock); #1;
    end
    cl_rx_ready[1] = 1'b1;
    rx_send(8'h66);
    wait_drain("t4");

    // 5: frame to nonexistent client 9 is swallowed, next frame reaches client 0
    rx_q.push_back({4'd0, 8'h88});
    rx_send(8'h09); rx_send(8'h00); rx_send(8'h77);
    rx_send(8'h00); rx_send(8'h00); rx_send(8'h88);
    wait_drain("t5");

    // 6: reset in the middle of a client 0 payload
    exp_frame(0, 8'd4, '{8'hC0, 8'hC1});
    fork
      send_tx(0, 8'd4, '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4});
      begin
        int t = 0;
        while (tx_q.size() != 0 && t < 100) begin @(negedge clock); #1; t++; end
        @(posedge clock); #2;
        check("t6_pre_rst_valid", 32'(serial_out_valid), 32'd1);
        reset = 1'b0; #1;
        check("t6_rst_sout_valid", 32'(serial_out_valid), 32'd0);
        check("t6_rst_tx_ready",   32'(cl_tx_ready),      32'd0);
        check("t6_rst_sin_ready",  32'(serial_in_ready),  32'd0);
      end
    join
    repeat (2) @(posedge clock);
    check("t6_no_extra_bytes", 32'(tx_q.size()), 32'd0);
    #1; reset = 1'b1;
    exp_frame(1, 8'd0, '{8'hD1});
    exp_frame(2, 8'd0, '{8'hD2});
    fork
      send_tx(1, 8'd0, '{8'hD1});
      send_tx(2, 8'd0, '{8'hD2});
    join
    wait_drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
